// File: rtl/shift_left_pkg.sv
// Shared types and sizing for the lane shifter.
// Lane 0 sits in the least significant bits.
package shift_left_pkg;
  localparam int LANE_W    = 12;
  localparam int LANES     = 8;
  localparam int MAX_SHIFT = 5;
  localparam int SHIFT_W   = 3;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [LANES-1:0] vec_t;
endpackage

// File: rtl/shift_left_lane_mux.sv
// One output lane: pick fill or an input lane
// from LANE down to LANE-MAX_SHIFT by shift.
module shift_left_lane_mux
  import shift_left_pkg::*;
#(
  parameter int LANE = 0
) (
  input  vec_t               in,
  input  lane_t              fill,
  input  logic [SHIFT_W-1:0] shift,
  output lane_t              out
);

  lane_t src [MAX_SHIFT+1];

  for (genvar k = 0; k <= MAX_SHIFT; k++) begin : g_src
    if (LANE >= k) begin : g_in
      assign src[k] = in[LANE-k];
    end else begin : g_fill
      assign src[k] = fill;
    end
  end

  // select the source for this lane
  always_comb begin
    out = fill;
    if (shift <= SHIFT_W'(MAX_SHIFT)) begin
      out = src[shift];
    end
  end

endmodule

// File: rtl/shift_left_lanes.sv
// Lane-granular left shifter, one register stage.
// Illegal shift amounts force a zero, invalid result.
module shift_left_lanes
  import shift_left_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] in,
  input  logic [SHIFT_W-1:0]      shift,
  input  logic [LANE_W-1:0]       fill,
  output logic [LANES*LANE_W-1:0] out,
  output logic                    out_valid
);

  vec_t in_v;
  vec_t mux_v;
  logic legal;

  assign in_v  = in;
  assign legal = (shift <= SHIFT_W'(MAX_SHIFT));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    shift_left_lane_mux #(
      .LANE (i)
    ) u_mux (
      .in    (in_v),
      .fill  (fill),
      .shift (shift),
      .out   (mux_v[i])
    );
  end

  // output register; illegal shifts clear data and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (legal) begin
      out       <= mux_v;
      out_valid <= 1'b1;
    end else begin
      out       <= '0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_left_lanes.sv
// Directed and random checks for shift_left_lanes.
// Expected values come from constants and a shift model.
module tb_shift_left_lanes;

  logic        clk;
  logic        rst;
  logic [95:0] in;
  logic [2:0]  shift;
  logic [11:0] fill;
  logic [95:0] out;
  logic        out_valid;

  int checks;
  int errors;

  localparam logic [95:0] SWEEP =
    96'h777_666_555_444_333_222_111_000;

  shift_left_lanes dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .shift     (shift),
    .fill      (fill),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [95:0] got,
    input logic [95:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] model(
    input logic [95:0] v,
    input logic [2:0]  s,
    input logic [11:0] f
  );
    logic [95:0] rep;
    logic [95:0] mask;
    if (s > 3'd5) return '0;
    rep  = {8{f}};
    mask = (96'h1 << (12 * s)) - 96'h1;
    return (v << (12 * s)) | (rep & mask);
  endfunction

  task automatic step(
    input logic        r,
    input logic [95:0] v,
    input logic [2:0]  s,
    input logic [11:0] f
  );
    rst   = r;
    in    = v;
    shift = s;
    fill  = f;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(
    input string       tag,
    input logic [95:0] v,
    input logic [2:0]  s,
    input logic [11:0] f
  );
    step(1'b0, v, s, f);
    check({tag, "_out"}, out, model(v, s, f));
    check({tag, "_vld"}, {95'd0, out_valid},
          {95'd0, (s <= 3'd5)});
  endtask

  initial begin
    logic [95:0] v;
    logic [2:0]  s;
    logic [11:0] f;
    checks = 0;
    errors = 0;

    step(1'b1, SWEEP, 3'd2, 12'hAAA);
    check("rst1_out", out, 96'h0);
    check("rst1_vld", {95'd0, out_valid}, 96'h0);
    step(1'b1, ~SWEEP, 3'd1, 12'h123);
    check("rst2_out", out, 96'h0);
    check("rst2_vld", {95'd0, out_valid}, 96'h0);

    step(1'b0, SWEEP, 3'd0, 12'hAAA);
    check("sh0_out", out, SWEEP);
    check("sh0_vld", {95'd0, out_valid}, 96'h1);
    step(1'b0, SWEEP, 3'd2, 12'hAAA);
    check("sh2_out", out,
          96'h555_444_333_222_111_000_AAA_AAA);
    check("sh2_vld", {95'd0, out_valid}, 96'h1);
    step(1'b0, SWEEP, 3'd5, 12'hAAA);
    check("sh5_out", out,
          96'h222_111_000_AAA_AAA_AAA_AAA_AAA);
    check("sh5_vld", {95'd0, out_valid}, 96'h1);
    step_chk("sh1", SWEEP, 3'd1, 12'hAAA);
    step_chk("sh3", SWEEP, 3'd3, 12'hAAA);
    step_chk("sh4", SWEEP, 3'd4, 12'hAAA);

    step(1'b0, SWEEP, 3'd6, 12'hAAA);
    check("sh6_out", out, 96'h0);
    check("sh6_vld", {95'd0, out_valid}, 96'h0);
    step(1'b0, ~SWEEP, 3'd7, 12'h555);
    check("sh7_out", out, 96'h0);
    check("sh7_vld", {95'd0, out_valid}, 96'h0);
    step(1'b0, SWEEP, 3'd1, 12'hFFF);
    check("rec_out", out,
          96'h666_555_444_333_222_111_000_FFF);
    check("rec_vld", {95'd0, out_valid}, 96'h1);

    for (int i = 0; i < 8; i++) begin
      v = {$urandom, $urandom, $urandom};
      s = 3'((i * 3) % 6);
      f = 12'($urandom);
      step_chk("pipe", v, s, f);
    end

    step_chk("mid_a", SWEEP, 3'd2, 12'hBBB);
    step(1'b1, SWEEP, 3'd3, 12'hCCC);
    check("mid_rst_out", out, 96'h0);
    check("mid_rst_vld", {95'd0, out_valid}, 96'h0);
    step(1'b0, SWEEP, 3'd3, 12'hCCC);
    check("mid_res_out", out,
          96'h444_333_222_111_000_CCC_CCC_CCC);
    check("mid_res_vld", {95'd0, out_valid}, 96'h1);

    for (int i = 0; i < 500; i++) begin
      v = {$urandom, $urandom, $urandom};
      s = 3'($urandom_range(0, 7));
      f = 12'($urandom);
      step_chk("rnd", v, s, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
